// File: rtl/ysyx_22040759_wraxi_pkg.sv
// rtl/ysyx_22040759_wraxi_pkg.sv - shared size/AXI constants and write-master state type
`timescale 1ns/1ps
package ysyx_22040759_wraxi_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [1:0] AXI_BURST_TYPE_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_BYTES_8    = 3'b011;

    localparam logic [2:0] AXI_PROT_UNPRIVILEGED_ACCESS = 3'b000;
    localparam logic [2:0] AXI_PROT_SECURE_ACCESS       = 3'b000;
    localparam logic [2:0] AXI_PROT_DATA_ACCESS         = 3'b000;

    localparam logic [3:0] AXI_ARCACHE_NORMAL_NON_CACHEABLE_NON_BUFFERABLE = 4'b0010;
    localparam logic [3:0] AXI_AWCACHE_NORMAL_NON_CACHEABLE_NON_BUFFERABLE =
        AXI_ARCACHE_NORMAL_NON_CACHEABLE_NON_BUFFERABLE;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_AW,
        WR_W,
        WR_RESP,
        WR_DONE
    } wr_state_e;

endpackage

// File: rtl/ysyx_22040759_wr_align.sv
// rtl/ysyx_22040759_wr_align.sv - beat data/strobe/len generator for an unaligned store
`timescale 1ns/1ps
module ysyx_22040759_wr_align
    import ysyx_22040759_wraxi_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [63:0] data_i,
    input  logic        beat_i,
    output logic [63:0] beat_data_o,
    output logic [7:0]  beat_strb_o,
    output logic [7:0]  awlen_o,
    output logic        overstep_o
);

    logic [3:0]  nbytes;
    logic [15:0] mask16;
    logic [6:0]  shamt;

    always_comb begin
        nbytes     = 4'd1 << size_i;
        overstep_o = ({1'b0, off_i} + nbytes - 4'd1) > 4'd7;
        mask16     = ((16'd1 << nbytes) - 16'd1) << off_i;
        shamt      = {1'b0, off_i, 3'b000};
        awlen_o    = {7'd0, overstep_o};
        // Second beat carries the bytes that spilled past lane 7 of the first.
        if (beat_i) begin
            beat_data_o = data_i >> (7'd64 - shamt);
            beat_strb_o = mask16[15:8];
        end else begin
            beat_data_o = data_i << shamt;
            beat_strb_o = mask16[7:0];
        end
    end

endmodule

// File: rtl/ysyx_22040759_wraxi.sv
// rtl/ysyx_22040759_wraxi.sv - AXI4 write master; YSYX_22040759_WR_AW_W_PARALLEL_EN overlaps AW and W
`timescale 1ns/1ps
module ysyx_22040759_wraxi
    import ysyx_22040759_wraxi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        wr_req_valid_i,
    input  logic [63:0]                 wr_addr_i,
    input  logic [1:0]                  wr_size_i,
    input  logic [63:0]                 wr_data_i,
    output logic                        wr_req_ready_o,
    output logic                        wr_done_o,
    output logic                        wr_err_o,

    input  logic                        axi_aw_ready_i,
    output logic                        axi_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
    output logic [2:0]                  axi_aw_prot_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_aw_user_o,
    output logic [7:0]                  axi_aw_len_o,
    output logic [2:0]                  axi_aw_size_o,
    output logic [1:0]                  axi_aw_burst_o,
    output logic                        axi_aw_lock_o,
    output logic [3:0]                  axi_aw_cache_o,
    output logic [3:0]                  axi_aw_qos_o,

    input  logic                        axi_w_ready_i,
    output logic                        axi_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
    output logic                        axi_w_last_o,

    output logic                        axi_b_ready_o,
    input  logic                        axi_b_valid_i,
    input  logic [1:0]                  axi_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_b_user_i
);

    wr_state_e   state_q, state_d;
    logic        beat_q, beat_d;
    logic        err_q, err_d;
    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic [63:0] data_q;

    logic        req_ready, aw_valid, w_valid, b_ready, done;
    logic        accept;
    logic [63:0] beat_data;
    logic [7:0]  beat_strb;
    logic [7:0]  awlen;
    logic        overstep;
    logic        w_last;

`ifdef YSYX_22040759_WR_AW_W_PARALLEL_EN
    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;
`endif

    logic unused_ok;
    assign unused_ok = ^{axi_b_id_i, axi_b_user_i};

    ysyx_22040759_wr_align u_align (
        .off_i       (addr_q[2:0]),
        .size_i      (size_q),
        .data_i      (data_q),
        .beat_i      (beat_q),
        .beat_data_o (beat_data),
        .beat_strb_o (beat_strb),
        .awlen_o     (awlen),
        .overstep_o  (overstep)
    );

    assign w_last = (beat_q == overstep);
    assign accept = wr_req_valid_i && req_ready;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        err_d     = err_q;
        req_ready = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        done      = 1'b0;
`ifdef YSYX_22040759_WR_AW_W_PARALLEL_EN
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`endif
        unique case (state_q)
            WR_IDLE: begin
                req_ready = 1'b1;
                beat_d    = 1'b0;
                if (wr_req_valid_i) state_d = WR_AW;
            end
            WR_AW: begin
`ifdef YSYX_22040759_WR_AW_W_PARALLEL_EN
                // Each channel drops its valid once its own handshake is done.
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if (aw_valid && axi_aw_ready_i) aw_done_d = 1'b1;
                if (w_valid && axi_w_ready_i) begin
                    beat_d = beat_q + 1'b1;
                    if (w_last) w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) state_d = WR_RESP;
`else
                aw_valid = 1'b1;
                if (axi_aw_ready_i) state_d = WR_W;
`endif
            end
            WR_W: begin
                w_valid = 1'b1;
                if (axi_w_ready_i) begin
                    beat_d = beat_q + 1'b1;
                    if (w_last) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (axi_b_valid_i) begin
                    err_d   = (axi_b_resp_i != AXI_RESP_OKAY);
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                done    = 1'b1;
                beat_d  = 1'b0;
                state_d = WR_IDLE;
`ifdef YSYX_22040759_WR_AW_W_PARALLEL_EN
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
`endif
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_IDLE;
            beat_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 64'd0;
            size_q  <= 2'd0;
            data_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q <= wr_addr_i;
                size_q <= wr_size_i;
                data_q <= wr_data_i;
            end
        end
    end

`ifdef YSYX_22040759_WR_AW_W_PARALLEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
`endif

    // Ready is masked while rst is high so the arbiter never sees a phantom accept.
    assign wr_req_ready_o = req_ready && !rst;
    assign wr_done_o      = done;
    assign wr_err_o       = done && err_q;

    assign axi_aw_valid_o = aw_valid;
    assign axi_aw_addr_o  = {addr_q[63:3], 3'b000};
    assign axi_aw_prot_o  = AXI_PROT_UNPRIVILEGED_ACCESS | AXI_PROT_SECURE_ACCESS | AXI_PROT_DATA_ACCESS;
    assign axi_aw_id_o    = '0;
    assign axi_aw_user_o  = '0;
    assign axi_aw_len_o   = awlen;
    assign axi_aw_size_o  = AXI_SIZE_BYTES_8;
    assign axi_aw_burst_o = AXI_BURST_TYPE_INCR;
    assign axi_aw_lock_o  = 1'b0;
    assign axi_aw_cache_o = AXI_AWCACHE_NORMAL_NON_CACHEABLE_NON_BUFFERABLE;
    assign axi_aw_qos_o   = 4'd0;

    assign axi_w_valid_o  = w_valid;
    assign axi_w_data_o   = beat_data;
    assign axi_w_strb_o   = beat_strb;
    assign axi_w_last_o   = w_last;

    assign axi_b_ready_o  = b_ready;

endmodule
